// File: rtl/dmem_req_sequencer.sv
// -----------------------------------------------------------------------------
// dmem_req_sequencer
//
// Puts MEM-stage data-memory accesses onto an SRAM-like bus with a split
// handshake: req/addr_ok for the address phase and data_ok for the data phase.
// While a transaction is outstanding the pipeline is stalled. Load data is
// held until the stage advances. If an exception flush arrives mid-transaction,
// the bus handshake still runs to completion and the returned data is dropped.
//
// Ports
//   clk, resetn         clock, asynchronous active-low reset
//   mem_en/wsel/size/   MEM-stage request (wsel==0 means load); these inputs
//   addr/wdata          stay stable while stall=1
//   flush, stage_adv    kill of the instruction in MEM / MEM stage advancing
//   stall               pipeline stall request
//   rdata, rdata_vld    raw load word, held for the current instruction
//   data_*              SRAM-like bus (req, wr, size, addr, wdata, wstrb,
//                       addr_ok, data_ok, rdata)
//
// Optional build macro DMEM_PERF_CNT_EN adds these outputs:
//   perf_stall_cyc, perf_load_cnt, perf_store_cnt
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; bus driven straight from mem_* inputs
// REQ   | address phase pending, data_req held until data_addr_ok
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | result held for the instruction until stage_adv or flush
// -----------------------------------------------------------------------------
module dmem_req_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_en,
    input  logic [3:0]        mem_wsel,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    input  logic              stage_adv,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cyc,
    output logic [CNT_W-1:0]  perf_load_cnt,
    output logic [CNT_W-1:0]  perf_store_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                killed_q, killed_d;
    logic                lat_wr_q, lat_wr_d;
    logic [1:0]          lat_size_q, lat_size_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [3:0]          lat_wstrb_q, lat_wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_vld_q, rdata_vld_d;
    logic                done_ld, done_st;

    // A flush that arrives in the same cycle as data_ok kills the result too.
    logic kill_now;
    assign kill_now = killed_q | flush;

    always_comb begin
        state_d     = state_q;
        killed_d    = killed_q;
        lat_wr_d    = lat_wr_q;
        lat_size_d  = lat_size_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_wstrb_d = lat_wstrb_q;
        rdata_d     = rdata_q;
        rdata_vld_d = rdata_vld_q;
        done_ld     = 1'b0;
        done_st     = 1'b0;

        stall      = 1'b0;
        data_req   = 1'b0;
        data_wr    = lat_wr_q;
        data_size  = lat_size_q;
        data_addr  = lat_addr_q;
        data_wdata = lat_wdata_q;
        data_wstrb = lat_wstrb_q;

        case (state_q)
            S_IDLE: begin
                data_wr    = |mem_wsel;
                data_size  = mem_size;
                data_addr  = mem_addr;
                data_wdata = mem_wdata;
                data_wstrb = mem_wsel;
                if (mem_en && !flush) begin
                    data_req    = 1'b1;
                    stall       = 1'b1;
                    lat_wr_d    = |mem_wsel;
                    lat_size_d  = mem_size;
                    lat_addr_d  = mem_addr;
                    lat_wdata_d = mem_wdata;
                    lat_wstrb_d = mem_wsel;
                    state_d     = data_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // The request is never retracted, even on flush.
                data_req = 1'b1;
                // Once killed, the stall belongs to the next instruction.
                stall    = killed_q ? mem_en : !flush;
                if (flush) killed_d = 1'b1;
                if (data_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                stall = killed_q ? mem_en : !flush;
                if (flush) killed_d = 1'b1;
                if (data_data_ok) begin
                    if (kill_now) begin
                        killed_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        if (!lat_wr_q) begin
                            rdata_d     = data_rdata;
                            rdata_vld_d = 1'b1;
                            done_ld     = 1'b1;
                        end else begin
                            done_st     = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (stage_adv || flush) begin
                    rdata_vld_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            killed_q    <= 1'b0;
            lat_wr_q    <= 1'b0;
            lat_size_q  <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_wstrb_q <= '0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            killed_q    <= killed_d;
            lat_wr_q    <= lat_wr_d;
            lat_size_q  <= lat_size_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_wstrb_q <= lat_wstrb_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
        end
    end

    assign rdata     = rdata_q;
    assign rdata_vld = rdata_vld_q;

`ifdef DMEM_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q + (stall ? CNT_W'(1) : CNT_W'(0));
        load_cnt_d  = load_cnt_q + (done_ld ? CNT_W'(1) : CNT_W'(0));
        store_cnt_d = store_cnt_q + (done_st ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cyc_q <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_load_cnt  = load_cnt_q;
    assign perf_store_cnt = store_cnt_q;
`else
    // Completion strobes only feed the counters; tie them off in this build.
    logic unused_done;
    assign unused_done = done_ld | done_st;
`endif

endmodule

// File: tb/tb_dmem_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dmem_req_sequencer
//
// The stimulus is a linear sequence of directed scenarios followed by random
// single transactions. The expected behaviour of each transaction comes from
// its shape: the addr_ok delay, the data_ok delay and the hold time in DONE.
// A small model tracks the last completed load word and the transaction counts.
// -----------------------------------------------------------------------------
module tb_dmem_req_sequencer;

    logic        clk;
    logic        resetn;
    logic        mem_en;
    logic [3:0]  mem_wsel;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        stage_adv;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_vld;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_load_cnt;
    logic [31:0] perf_store_cnt;
`endif

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_rdata;
    int          exp_loads;
    int          exp_stores;

    dmem_req_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en       (mem_en),
        .mem_wsel     (mem_wsel),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .stage_adv    (stage_adv),
        .stall        (stall),
        .rdata        (rdata),
        .rdata_vld    (rdata_vld),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
`ifdef DMEM_PERF_CNT_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_load_cnt  (perf_load_cnt),
        .perf_store_cnt (perf_store_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        mem_en       = 1'b0;
        mem_wsel     = 4'b0000;
        mem_size     = 2'd0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        flush        = 1'b0;
        stage_adv    = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
    endtask

    function automatic logic [3:0] strobe_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    strobe_of = 4'b0001 << a;
            2'd1:    strobe_of = a[1] ? 4'b1100 : 4'b0011;
            default: strobe_of = 4'b1111;
        endcase
    endfunction

    // A single transaction, starting in IDLE with cycle 0 as the issue cycle.
    // addr_ok arrives at cycle da and data_ok at cycle da+1+dw.
    // The task then holds DONE for `hold` cycles and lets the stage advance.
    task automatic run_txn(input logic [3:0] wsel, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int da, input int dw, input logic [31:0] rd,
                           input int hold);
        logic is_wr;
        is_wr = |wsel;
        for (int c = 0; c <= da + dw + 1; c++) begin
            mem_en       = 1'b1;
            mem_wsel     = wsel;
            mem_size     = size;
            mem_addr     = addr;
            mem_wdata    = wdata;
            flush        = 1'b0;
            stage_adv    = 1'b0;
            data_addr_ok = (c == da);
            data_data_ok = (c == da + 1 + dw);
            data_rdata   = (c == da + 1 + dw) ? rd : $urandom;
            settle();
            check("txn_req", {31'b0, data_req}, {31'b0, (c <= da)});
            check("txn_stall", {31'b0, stall}, 32'd1);
            if (c <= da) begin
                check("txn_addr", data_addr, addr);
                check("txn_wstrb", {28'b0, data_wstrb}, {28'b0, wsel});
                check("txn_wr", {31'b0, data_wr}, {31'b0, is_wr});
                check("txn_size", {30'b0, data_size}, {30'b0, size});
                if (is_wr) check("txn_wdata", data_wdata, wdata);
            end
            if (c == 0) check("txn_vld_pre", {31'b0, rdata_vld}, 32'd0);
            tick();
        end
        if (!is_wr) begin
            exp_rdata = rd;
            exp_loads++;
        end else begin
            exp_stores++;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
        for (int h = 0; h < hold; h++) begin
            settle();
            check("done_stall", {31'b0, stall}, 32'd0);
            check("done_req", {31'b0, data_req}, 32'd0);
            check("done_vld", {31'b0, rdata_vld}, {31'b0, !is_wr});
            check("done_rdata", rdata, exp_rdata);
            tick();
        end
        stage_adv = 1'b1;
        settle();
        check("adv_req", {31'b0, data_req}, 32'd0);
        check("adv_stall", {31'b0, stall}, 32'd0);
        check("adv_vld", {31'b0, rdata_vld}, {31'b0, !is_wr});
        tick();
        idle_inputs();
        settle();
        check("post_vld", {31'b0, rdata_vld}, 32'd0);
        check("post_rdata", rdata, exp_rdata);
        check("post_req", {31'b0, data_req}, 32'd0);
        tick();
    endtask

    initial begin
        logic [1:0]  rs;
        logic [31:0] ra;
        logic        rw;

        tests_run    = 0;
        tests_failed = 0;
        exp_rdata    = 32'h0;
        exp_loads    = 0;
        exp_stores   = 0;
        resetn       = 1'b0;
        idle_inputs();

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, data_req}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_vld", {31'b0, rdata_vld}, 32'd0);
        resetn = 1'b1;
        tick();

        // Word load: immediate addr_ok, data_ok two cycles after issue.
        run_txn(4'b0000, 2'd2, 32'h0000_1000, 32'h0, 0, 1, 32'hDEAD_BEEF, 1);

        // Store byte with addr_ok delayed by three cycles; rdata stays put.
        run_txn(4'b0100, 2'd0, 32'h0000_2002, 32'h5A5A_5A5A, 3, 1, 32'hFFFF_0000, 1);

        // DONE held for three cycles without stage_adv.
        run_txn(4'b0000, 2'd2, 32'h0000_1004, 32'h0, 1, 0, 32'hCAFE_F00D, 3);

        // Flush in WAIT.
        mem_en = 1'b1; mem_wsel = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0000_2000;
        data_addr_ok = 1'b1;
        settle();
        check("fw_issue_req", {31'b0, data_req}, 32'd1);
        check("fw_issue_stall", {31'b0, stall}, 32'd1);
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        settle();
        check("fw_flush_stall", {31'b0, stall}, 32'd0);
        check("fw_flush_req", {31'b0, data_req}, 32'd0);
        tick();
        idle_inputs();
        settle();
        check("fw_killed_stall", {31'b0, stall}, 32'd0);
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1234_5678;
        settle();
        check("fw_dok_stall", {31'b0, stall}, 32'd0);
        tick();
        idle_inputs();
        settle();
        check("fw_rdata", rdata, exp_rdata);
        check("fw_vld", {31'b0, rdata_vld}, 32'd0);
        tick();
        run_txn(4'b0011, 2'd1, 32'h0000_3000, 32'hA5A5_1234, 0, 0, 32'h0, 0);

        // Flush in REQ, then a new load waits for the killed data_ok.
        mem_en = 1'b1; mem_wsel = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0000_3000;
        settle();
        check("fr_issue_req", {31'b0, data_req}, 32'd1);
        tick();
        flush = 1'b1;
        settle();
        check("fr_flush_req", {31'b0, data_req}, 32'd1);
        check("fr_flush_stall", {31'b0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        mem_addr = 32'h0000_4000;
        settle();
        check("fr_new_req", {31'b0, data_req}, 32'd1);
        check("fr_held_addr", data_addr, 32'h0000_3000);
        check("fr_new_stall", {31'b0, stall}, 32'd1);
        tick();
        data_addr_ok = 1'b1;
        settle();
        check("fr_aok_req", {31'b0, data_req}, 32'd1);
        tick();
        data_addr_ok = 1'b0;
        settle();
        check("fr_wait_req", {31'b0, data_req}, 32'd0);
        check("fr_wait_stall", {31'b0, stall}, 32'd1);
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        settle();
        check("fr_dok_req", {31'b0, data_req}, 32'd0);
        check("fr_dok_stall", {31'b0, stall}, 32'd1);
        tick();
        data_data_ok = 1'b0;
        settle();
        check("fr_drop_rdata", rdata, exp_rdata);
        run_txn(4'b0000, 2'd2, 32'h0000_4000, 32'h0, 1, 1, 32'h0BAD_C0DE, 1);

        // Reset asserted mid-WAIT.
        mem_en = 1'b1; mem_wsel = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0000_5000;
        data_addr_ok = 1'b1;
        settle();
        tick();
        data_addr_ok = 1'b0;
        settle();
        check("rw_wait_stall", {31'b0, stall}, 32'd1);
        resetn = 1'b0;
        mem_en = 1'b0;
        #1;
        exp_rdata  = 32'h0;
        exp_loads  = 0;
        exp_stores = 0;
        check("rw_req", {31'b0, data_req}, 32'd0);
        check("rw_stall", {31'b0, stall}, 32'd0);
        check("rw_rdata", rdata, 32'h0);
        check("rw_vld", {31'b0, rdata_vld}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        run_txn(4'b0000, 2'd2, 32'h0000_6000, 32'h0, 0, 0, 32'h1357_9BDF, 1);

        // Random transactions.
        for (int n = 0; n < 25; n++) begin
            rs = 2'($urandom_range(2, 0));
            ra = $urandom;
            if (rs == 2'd1) ra[0] = 1'b0;
            if (rs == 2'd2) ra[1:0] = 2'b00;
            rw = 1'($urandom_range(1, 0));
            run_txn(rw ? strobe_of(rs, ra[1:0]) : 4'b0000, rs, ra, $urandom,
                    int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                    $urandom, int'($urandom_range(2, 0)));
        end

`ifdef DMEM_PERF_CNT_EN
        check("perf_loads", perf_load_cnt, 32'(exp_loads));
        check("perf_stores", perf_store_cnt, 32'(exp_stores));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
